stopwatch_ctrl: RTL and testbench

//  Front-end controller that drives the stopwatch counter chain (the Mod-N digit counters).

---
 rtl/stopwatch_if.sv | 22 ++
 rtl/stopwatch_ctrl.sv | 117 +++++++++++
 tb/tb_stopwatch_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_if.sv
// Button inputs and counter/display control outputs of the stopwatch front-end.
// The board/bench side uses master; the controller uses slave.
interface stopwatch_if;
    logic       btn_start;
    logic       btn_lap;
    logic       btn_clear;
    logic       start_resume;
    logic       stop;
    logic       cnt_reset;
    logic       lap_hold;
    logic [1:0] state;

    modport master (
        output btn_start, btn_lap, btn_clear,
        input  start_resume, stop, cnt_reset, lap_hold, state
    );

    modport slave (
        input  btn_start, btn_lap, btn_clear,
        output start_resume, stop, cnt_reset, lap_hold, state
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-end: synchronise/debounce/edge-detect three buttons and run the
// CLEARED/RUNNING/PAUSED/LAP control FSM that drives the counter chain and display freeze.
module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DB_W            = 20
) (
    input logic        clk,
    input logic        reset,
    stopwatch_if.slave bus
);
    localparam int B_LAP   = 0;
    localparam int B_START = 1;
    localparam int B_CLEAR = 2;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        CLEARED = 2'b00,
        RUNNING = 2'b01,
        PAUSED  = 2'b10,
        LAP     = 2'b11
    } state_t;

    logic [2:0]      raw;
    logic [2:0]      s1;
    logic [2:0]      s2;
    logic [2:0]      db_level;
    logic [2:0]      db_prev;
    logic [2:0]      press;
    logic [DB_W-1:0] db_cnt [3];

    state_t state_q;
    state_t state_d;
    logic   clear_acc;
    logic   start_resume_q;
    logic   stop_q;
    logic   cnt_reset_q;
    logic   lap_hold_q;

    assign raw = {bus.btn_clear, bus.btn_start, bus.btn_lap};

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1       <= '0;
            s2       <= '0;
            db_level <= '0;
            db_prev  <= '0;
            press    <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            s1      <= raw;
            s2      <= s1;
            db_prev <= db_level;
            press   <= db_level & ~db_prev;
            // A level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
            for (int i = 0; i < 3; i++) begin
                if (s2[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_level[i] <= s2[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) state_q <= CLEARED;
        else        state_q <= state_d;
    end

    // Only the highest-priority event present is considered; the rest are dropped.
    always_comb begin
        state_d   = state_q;
        clear_acc = 1'b0;
        if (press[B_CLEAR]) begin
            if (state_q == CLEARED) begin
                clear_acc = 1'b1;
            end else if (state_q == PAUSED) begin
                state_d   = CLEARED;
                clear_acc = 1'b1;
            end
        end else if (press[B_START]) begin
            case (state_q)
                CLEARED: state_d = RUNNING;
                RUNNING: state_d = PAUSED;
                LAP:     state_d = PAUSED;
                PAUSED:  state_d = RUNNING;
                default: state_d = CLEARED;
            endcase
        end else if (press[B_LAP]) begin
            if (state_q == RUNNING)  state_d = LAP;
            else if (state_q == LAP) state_d = RUNNING;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            start_resume_q <= 1'b0;
            stop_q         <= 1'b0;
            lap_hold_q     <= 1'b0;
            cnt_reset_q    <= 1'b1;
        end else begin
            start_resume_q <= (state_d == RUNNING) || (state_d == LAP);
            stop_q         <= (state_d == PAUSED);
            lap_hold_q     <= (state_d == LAP);
            cnt_reset_q    <= clear_acc;
        end
    end

    assign bus.start_resume = start_resume_q;
    assign bus.stop         = stop_q;
    assign bus.lap_hold     = lap_hold_q;
    assign bus.cnt_reset    = cnt_reset_q;
    assign bus.state        = state_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: vector table, directed corner sequences and a randomized
// run compared every cycle against a window-based behavioural model.
module tb_stopwatch_ctrl;
    localparam int DC = 4;
    localparam logic [1:0] M_CLR = 2'b00;
    localparam logic [1:0] M_RUN = 2'b01;
    localparam logic [1:0] M_PAU = 2'b10;
    localparam logic [1:0] M_LAP = 2'b11;

    logic clk;
    logic reset;
    stopwatch_if bus ();

    stopwatch_ctrl #(.DEBOUNCE_CYCLES(DC), .DB_W(20)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a level flips once the last DC synchronised samples all differ
    // from it; a rising flip becomes an FSM event two clocks later.
    logic [DC:0] win [3];
    logic [1:0]  ev_pipe [3];
    logic [2:0]  lvl;
    logic [1:0]  m_state;
    logic        m_cr;
    logic        mon_en = 1'b0;

    always @(posedge clk) begin
        logic [2:0] rawv;
        logic [2:0] evt;
        logic       all_diff;
        rawv = {bus.btn_clear, bus.btn_start, bus.btn_lap};
        if (!reset) begin
            for (int b = 0; b < 3; b++) begin
                win[b]     = '0;
                ev_pipe[b] = '0;
            end
            lvl     = '0;
            m_state = M_CLR;
            m_cr    = 1'b1;
        end else begin
            for (int b = 0; b < 3; b++) begin
                evt[b]   = ev_pipe[b][1];
                all_diff = 1'b1;
                for (int j = 1; j <= DC; j++)
                    if (win[b][j] == lvl[b]) all_diff = 1'b0;
                ev_pipe[b] = {ev_pipe[b][0], all_diff & ~lvl[b]};
                if (all_diff) lvl[b] = ~lvl[b];
                win[b] = {win[b][DC-1:0], rawv[b]};
            end
            m_cr = 1'b0;
            if (evt[2]) begin
                if (m_state == M_CLR) m_cr = 1'b1;
                else if (m_state == M_PAU) begin
                    m_state = M_CLR;
                    m_cr    = 1'b1;
                end
            end else if (evt[1]) begin
                m_state = (m_state == M_RUN || m_state == M_LAP) ? M_PAU : M_RUN;
            end else if (evt[0]) begin
                if (m_state == M_RUN)      m_state = M_LAP;
                else if (m_state == M_LAP) m_state = M_RUN;
            end
        end
        mon_en = 1'b1;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("model_state", {2'b0, bus.state}, {2'b0, m_state});
            chk("model_outs", {bus.start_resume, bus.stop, bus.lap_hold, bus.cnt_reset},
                {(m_state == M_RUN || m_state == M_LAP), (m_state == M_PAU),
                 (m_state == M_LAP), m_cr});
            chk("inv_sr_stop", {3'b0, bus.start_resume & bus.stop}, 4'h0);
            chk("inv_cr_sr", {3'b0, bus.cnt_reset & bus.start_resume}, 4'h0);
        end
    end

    typedef struct {
        logic       rst_n;
        logic       st;
        logic       lp;
        logic       cl;
        int         cycles;
        logic [1:0] e_state;
        logic       e_sr;
        logic       e_stop;
        logic       e_cr;
        logic       e_lap;
    } vec_t;

    vec_t tbl [14];

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic st, input logic lp, input logic cl);
        bus.btn_start = st;
        bus.btn_lap   = lp;
        bus.btn_clear = cl;
    endtask

    task automatic press_release(input logic st, input logic lp, input logic cl);
        drive(st, lp, cl);
        cyc(10);
        drive(1'b0, 1'b0, 1'b0);
        cyc(10);
    endtask

    task automatic count_cr(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            cyc(1);
            if (bus.cnt_reset === 1'b1) cnt++;
        end
    endtask

    initial begin
        int crn;
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0);

        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3,  M_CLR, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1,  M_CLR, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3,  M_CLR, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 10, M_CLR, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 10, M_RUN, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 10, M_RUN, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 10, M_LAP, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 10, M_LAP, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 10, M_RUN, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 10, M_RUN, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 10, M_PAU, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 10, M_PAU, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 10, M_CLR, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 10, M_CLR, 1'b0, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 14; i++) begin
            reset = tbl[i].rst_n;
            drive(tbl[i].st, tbl[i].lp, tbl[i].cl);
            cyc(tbl[i].cycles);
            chk($sformatf("tbl%0d_state", i), {2'b0, bus.state}, {2'b0, tbl[i].e_state});
            chk($sformatf("tbl%0d_outs", i),
                {bus.start_resume, bus.stop, bus.lap_hold, bus.cnt_reset},
                {tbl[i].e_sr, tbl[i].e_stop, tbl[i].e_lap, tbl[i].e_cr});
        end

        // Press latency: first sampled at edge k, state changes at edge k+DC+3 exactly.
        drive(1'b1, 1'b0, 1'b0);
        cyc(DC + 3);
        chk("lat_early_state", {2'b0, bus.state}, {2'b0, M_CLR});
        chk("lat_early_sr", {3'b0, bus.start_resume}, 4'h0);
        cyc(1);
        chk("lat_state", {2'b0, bus.state}, {2'b0, M_RUN});
        chk("lat_sr", {3'b0, bus.start_resume}, 4'h1);
        drive(1'b0, 1'b0, 1'b0);
        cyc(10);

        // Clear while running is ignored.
        drive(1'b0, 1'b0, 1'b1);
        count_cr(12, crn);
        chk("clr_run_pulses", 4'(crn), 4'h0);
        chk("clr_run_state", {2'b0, bus.state}, {2'b0, M_RUN});
        drive(1'b0, 1'b0, 1'b0);
        cyc(10);

        // Clear from paused: exactly one cnt_reset clock.
        press_release(1'b1, 1'b0, 1'b0);
        chk("to_paused", {2'b0, bus.state}, {2'b0, M_PAU});
        drive(1'b0, 1'b0, 1'b1);
        count_cr(12, crn);
        chk("clr_pau_pulses", 4'(crn), 4'h1);
        chk("clr_pau_state", {2'b0, bus.state}, {2'b0, M_CLR});
        drive(1'b0, 1'b0, 1'b0);
        cyc(10);

        // Clear in CLEARED re-pulses cnt_reset.
        drive(1'b0, 1'b0, 1'b1);
        count_cr(12, crn);
        chk("clr_clr_pulses", 4'(crn), 4'h1);
        drive(1'b0, 1'b0, 1'b0);
        cyc(10);

        // Start and clear together from PAUSED: clear wins.
        press_release(1'b1, 1'b0, 1'b0);
        press_release(1'b1, 1'b0, 1'b0);
        chk("pau_again", {2'b0, bus.state}, {2'b0, M_PAU});
        drive(1'b1, 1'b0, 1'b1);
        count_cr(12, crn);
        chk("both_pulses", 4'(crn), 4'h1);
        chk("both_state", {2'b0, bus.state}, {2'b0, M_CLR});
        chk("both_sr", {3'b0, bus.start_resume}, 4'h0);
        drive(1'b0, 1'b0, 1'b0);
        cyc(10);

        // Reset while lap is mid-debounce in RUNNING; held lap is then ignored in CLEARED.
        press_release(1'b1, 1'b0, 1'b0);
        chk("run_again", {2'b0, bus.state}, {2'b0, M_RUN});
        drive(1'b0, 1'b1, 1'b0);
        cyc(3);
        reset = 1'b0;
        cyc(1);
        chk("mid_rst_state", {2'b0, bus.state}, {2'b0, M_CLR});
        chk("mid_rst_cr", {3'b0, bus.cnt_reset}, 4'h1);
        reset = 1'b1;
        cyc(12);
        chk("held_lap_state", {2'b0, bus.state}, {2'b0, M_CLR});
        chk("held_lap_hold", {3'b0, bus.lap_hold}, 4'h0);
        drive(1'b0, 1'b0, 1'b0);
        cyc(10);

        // Randomized segments: glitches, presses, overlaps and occasional resets.
        for (int s = 0; s < 400; s++) begin
            logic [2:0] b;
            b = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) b = 3'b000;
            drive(b[1], b[0], b[2]);
            reset = ($urandom_range(0, 39) != 0);
            cyc(1);
            reset = 1'b1;
            cyc($urandom_range(0, 11));
        end
        drive(1'b0, 1'b0, 1'b0);
        cyc(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
